// File: rtl/alu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_if : requester, response and ALU bus of alu_share_arbiter
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface alu_share_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp0_zero;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_data;
  logic              rsp1_zero;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  logic              busy;

  // Requesters plus the ALU itself
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready, rsp0_valid, rsp0_data, rsp0_zero,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready, rsp1_valid, rsp1_data, rsp1_zero,
    input  alu_a, alu_b, alu_op, busy,
    output alu_result, alu_zero
  );

  // The arbiter
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready, rsp0_valid, rsp0_data, rsp0_zero,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready, rsp1_valid, rsp1_data, rsp1_zero,
    output alu_a, alu_b, alu_op, busy,
    input  alu_result, alu_zero
  );
endinterface

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter : round-robin sharing of one registered ALU by two
// requesters. Define ALU_ARB_STRICT_PRIO_EN for fixed req0-first priority.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module alu_share_arbiter #(
  parameter int DATA_W  = 16,
  parameter int OP_W    = 3,
  parameter int IDLE_OP = 7
) (
  input  wire logic         clk,
  input  wire logic         rst,
  alu_share_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;

  localparam logic [OP_W-1:0] C_IDLE_OP = OP_W'(IDLE_OP);

  logic [1:0]        r_state;
  logic              r_winner;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [OP_W-1:0]   r_alu_op;
  logic              r_rsp0_valid;
  logic [DATA_W-1:0] r_rsp0_data;
  logic              r_rsp0_zero;
  logic              r_rsp1_valid;
  logic [DATA_W-1:0] r_rsp1_data;
  logic              r_rsp1_zero;

  logic w_idle;
  logic w_gnt0;
  logic w_gnt1;

  assign w_idle = (r_state == S_IDLE);

`ifdef ALU_ARB_STRICT_PRIO_EN
  assign w_gnt0 = bus.req0_valid;
  assign w_gnt1 = bus.req1_valid & ~bus.req0_valid;
`else
  // r_prio names the requester that wins a tie
  logic r_prio;
  assign w_gnt0 = bus.req0_valid & (~bus.req1_valid | ~r_prio);
  assign w_gnt1 = bus.req1_valid & (~bus.req0_valid |  r_prio);
`endif

  assign bus.req0_ready = w_idle & w_gnt0;
  assign bus.req1_ready = w_idle & w_gnt1;
  assign bus.busy       = (r_state == S_ISSUE) || (r_state == S_CAPTURE);

  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_op     = r_alu_op;
  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp0_data  = r_rsp0_data;
  assign bus.rsp0_zero  = r_rsp0_zero;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp1_data  = r_rsp1_data;
  assign bus.rsp1_zero  = r_rsp1_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_winner     <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= C_IDLE_OP;
      r_rsp0_valid <= 1'b0;
      r_rsp0_data  <= '0;
      r_rsp0_zero  <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp1_data  <= '0;
      r_rsp1_zero  <= 1'b0;
`ifndef ALU_ARB_STRICT_PRIO_EN
      r_prio       <= 1'b0;
`endif
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req0_ready) begin
            r_alu_a  <= bus.req0_a;
            r_alu_b  <= bus.req0_b;
            r_alu_op <= bus.req0_op;
            r_winner <= 1'b0;
            r_state  <= S_ISSUE;
          end else if (bus.req1_ready) begin
            r_alu_a  <= bus.req1_a;
            r_alu_b  <= bus.req1_b;
            r_alu_op <= bus.req1_op;
            r_winner <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // ALU registers its result on this edge
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (r_winner) begin
            r_rsp1_valid <= 1'b1;
            r_rsp1_data  <= bus.alu_result;
            r_rsp1_zero  <= bus.alu_zero;
          end else begin
            r_rsp0_valid <= 1'b1;
            r_rsp0_data  <= bus.alu_result;
            r_rsp0_zero  <= bus.alu_zero;
          end
`ifndef ALU_ARB_STRICT_PRIO_EN
          r_prio <= ~r_winner;
`endif
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one registered 16-bit ALU between two requesters (req0 = instruction datapath, req1 = address/PC-update path). It accepts one operation at a time over a valid/ready handshake and drives the ALU operand and opcode inputs. It waits out the ALU's one-clock registered latency, then returns the result and zero flag to the winning requester as a one-cycle response pulse.

Parameters:
DATA_W, 16, operand/result width
OP_W, 3, ALU opcode width (0 add, 1 sub, 2 or, 3 and, 4 shl, 5 shr, 6 xor, 7 zero)
IDLE_OP, 7, opcode driven on alu_op out of reset

Ports:
CLK  in  1  clock, all state updates on rising edge
Reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation pending
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  DATA_W  requester 0 first operand
req0_b  in  DATA_W  requester 0 second operand
req0_op  in  OP_W  requester 0 opcode
rsp0_valid  out  1  one-cycle pulse, rsp0_data/rsp0_zero valid
rsp0_data  out  DATA_W  result for requester 0
rsp0_zero  out  1  ALU zero flag for requester 0
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
rsp1_valid, rsp1_data, rsp1_zero  same as requester 0, for requester 1
alu_a  out  DATA_W  to ALU first input
alu_b  out  DATA_W  to ALU second input
alu_op  out  OP_W  to ALU opcode
alu_result  in  DATA_W  from ALU OutputData
alu_zero  in  1  from ALU Zero
busy  out  1  high in ISSUE and CAPTURE

Behaviour:
- Interface: one clock, CLK; Reset is synchronous and active-high. Reset is sampled only on the CLK rising edge.
- Reset values:
  - state=IDLE, prio pointer=0.
  - alu_a=0, alu_b=0, alu_op=IDLE_OP.
  - rsp*_valid=0, rsp*_data=0, rsp*_zero=0, busy=0.
- FSM states: IDLE -> ISSUE -> CAPTURE -> IDLE. Unconditional after the grant; no stalls.
- IDLE, grant:
  - Only one reqN_valid high: grant N.
  - Both high: grant the requester named by the pointer.
  - reqN_ready = (state==IDLE) && grantN. Combinational; at most one ready high.
- IDLE, accept:
  - Handshake completes when valid && ready at the rising edge.
  - At that edge, register reqN_a/b/op into alu_a/b/op, record winner id, move to ISSUE.
- Requester rules:
  - reqN_valid must not depend on reqN_ready.
  - Operands must stay stable from valid assertion until acceptance.
  - Operands are not sampled after the accept edge.
- ISSUE: alu_a/b/op held stable; the ALU registers its result at the edge ending ISSUE.
- CAPTURE:
  - alu_result/alu_zero are valid.
  - At the edge ending CAPTURE: load rsp<winner>_data/zero, set rsp<winner>_valid=1, set pointer = other requester, return to IDLE.
- rsp*_valid:
  - Exactly one cycle long.
  - No backpressure; requesters must consume it.
  - rsp*_data/zero hold their value until the next response to the same requester.
- Latency and throughput:
  - Accept edge at cycle T -> rsp valid during cycle T+3.
  - A new accept may occur in the same cycle as the response pulse.
  - Maximum throughput is one operation per 3 cycles.
- alu_a/b/op hold their last issued values while in IDLE.
- Arithmetic is done entirely by the ALU; the arbiter never modifies data widths or values.
- Boundary conditions:
  - Neither valid in IDLE: stay IDLE, pointer unchanged.
  - Pointer changes only on a completed operation.
  - One requester continuously valid and the other idle: it is granted every slot.
  - Reset in ISSUE or CAPTURE: operation is abandoned, no rsp pulse is produced, all outputs return to reset values.
  - reqN_valid deasserted in IDLE before acceptance: no grant, pointer unchanged.

Optional Feature:
ALU_ARB_STRICT_PRIO_EN
- Defined: round-robin pointer removed; req0 always wins when both are valid; req1 is granted only when req0_valid=0.
- Undefined: round-robin as above.
- All timing is identical in both builds.

Test Plan:
- Single add: Reset, then req0 {a=5, b=3, op=0} -> req0_ready 1 cycle; rsp0_valid at T+3, rsp0_data=8, rsp0_zero=0; rsp1_valid never set.
- Sub to zero: req1 {a=9, b=9, op=1} -> rsp1_data=0, rsp1_zero=1; busy high exactly cycles T+1 and T+2.
- Contention after reset: both valid at once, req0 {1, 1, op=0}, req1 {6, 2, op=1} -> req0 served first (rsp0_data=2), then req1 accepted in the rsp0 cycle (rsp1_data=4, 3 cycles later).
- Sustained contention: both valid for 12 cycles -> grants alternate 0,1,0,1 with a new accept every 3 cycles; no starvation.
- Reset mid-op: req0 accepted, Reset asserted during CAPTURE -> no rsp0_valid pulse; alu_op=7, alu_a=0, busy=0; next grant goes to req0 (pointer=0).
- With ALU_ARB_STRICT_PRIO_EN: both valid continuously for 9 cycles -> three consecutive req0 grants, zero req1 grants; req1 granted on the first IDLE cycle after req0_valid drops.
